sync_fifo_width_packer: RTL and testbench
=========================================

Name: sync_fifo_width_packer

Overview:
- Upstream stage of sync_fifo. Packs RATIO narrow words into one FIFO-width word and presents it on a valid/ready interface that drives the FIFO write side.
- A lane-valid mask accompanies each word so partial words are flushed on a last marker.
- Output is registered, so there is no combinational path from upstream data into the FIFO write data.

Parameters:
- IN_WIDTH, 8, width of one narrow input word (one lane)
- RATIO, 4, number of lanes per output word; legal values are 2 and up
- OUT_WIDTH, IN_WIDTH*RATIO, packed output width; must equal the FIFO DATA_WIDTH
- CNT_WIDTH, $clog2(RATIO), width of the lane counter

Ports:
- i_clk  in  1  single clock; all flops are on the rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_valid_s  in  1  upstream word valid
- i_data  in  IN_WIDTH  upstream word
- i_last  in  1  qualifies i_valid_s; ends the current word and forces a flush
- o_ready_s  out  1  packer can accept an upstream word this cycle
- o_valid_m  out  1  packed word valid; connects to FIFO i_valid_s
- o_data  out  OUT_WIDTH  packed word; connects to FIFO i_datain
- o_keep  out  RATIO  lane-valid mask for o_data; bit k means lane k is valid
- i_ready_m  in  1  downstream accept; connects to FIFO o_ready_s

Behaviour:
- Handshakes:
  - Input transfer: i_valid_s & o_ready_s at the clock edge.
  - Output transfer: o_valid_m & i_ready_m at the clock edge.
- Storage:
  - Accumulator acc: (RATIO-1) lanes.
  - Lane counter cnt: 0..RATIO-1.
  - Output register: o_data, o_keep, o_valid_m.
- out_free = !o_valid_m | i_ready_m. This is combinational and is the only i_ready_m-to-o_ready_s path.
- States:
  - ACCUM (the reset state).
  - FLUSH_PEND: a completed word is waiting for out_free.
- o_ready_s:
  - In ACCUM: (cnt != RATIO-1) | out_free.
  - In FLUSH_PEND: 0.
  - Forced to 0 while i_rst_n is low.
- Input transfer in ACCUM:
  - cnt < RATIO-1 and i_last=0: write lane cnt of acc; cnt+1.
  - cnt == RATIO-1 (o_ready_s guarantees out_free): load the output register with acc plus the new lane; o_keep = all ones; cnt = 0; o_valid_m = 1 next cycle.
  - i_last=1, cnt < RATIO-1, out_free: load the output register with lanes 0..cnt; o_keep = (1<<(cnt+1))-1; unused lanes are 0; cnt = 0.
  - i_last=1, cnt < RATIO-1, !out_free: write the lane into acc; go to FLUSH_PEND; hold cnt as the final lane index.
- FLUSH_PEND:
  - On out_free, load the output register from acc with o_keep = (1<<(cnt+1))-1; cnt = 0; return to ACCUM.
  - No input is accepted while in this state.
- Output register:
  - Cleared (o_valid_m = 0) on an output transfer with no same-cycle load.
  - A same-cycle drain plus load keeps o_valid_m = 1 with the new contents, giving back-to-back words with no bubble.
  - o_data and o_keep are stable while o_valid_m=1 and i_ready_m=0.
- Latency: one cycle from the completing input transfer to o_valid_m.
- Throughput: one input word per cycle while the FIFO is not full.
- i_last on lane RATIO-1 behaves as a normal full word.
- i_last with cnt=0 flushes a single-lane word with o_keep = 1.
- Reset, asynchronous (including mid-word or mid-flush):
  - cnt = 0, state ACCUM, acc = 0.
  - o_valid_m = 0, o_data = 0, o_keep = 0.
  - Any partial word is discarded.
- No input transfer can occur when o_ready_s=0; i_data/i_last are ignored unless i_valid_s=1.

Optional Feature:
- Macro: SYNC_FIFO_PACKER_MSB_FIRST_EN
- Defined: lane k maps to o_data[OUT_WIDTH-1-k*IN_WIDTH -: IN_WIDTH] (first word in the MSBs). o_keep bit k still refers to the k-th received word, so a partial flush marks the high lanes.
- Undefined: lane k maps to o_data[k*IN_WIDTH +: IN_WIDTH] (first word in the LSBs).
- Control timing is identical in both builds.

Test Plan:
- Reset then idle: after release, o_ready_s=1, o_valid_m=0, o_data=0, o_keep=0; asserting i_rst_n low mid-word clears cnt and no word appears.
- i_ready_m=1, feed 0x11,0x22,0x33,0x44 on consecutive cycles: one cycle after 0x44, o_valid_m=1, o_data=0x44332211, o_keep=4'b1111; repeating 8 bytes gives two words with no bubble.
- Feed 0xAA, 0xBB with i_last on 0xBB, i_ready_m=1: o_data=0x0000BBAA, o_keep=4'b0011.
- Hold i_ready_m=0 with a word pending, feed 0x01,0x02,0x03: o_ready_s drops to 0 at cnt=3 and o_data stays stable. Raise i_ready_m: the pending word drains, the 4th byte is accepted in the same cycle, and the next word follows.
- i_ready_m=0 with a word pending, then 0x5A with i_last at cnt=0: FLUSH_PEND, o_ready_s=0. Release i_ready_m: next word is 0x0000005A with o_keep=4'b0001, then back to ACCUM.
- Build with SYNC_FIFO_PACKER_MSB_FIRST_EN and feed 0x11..0x44: o_data=0x11223344, o_keep=4'b1111.

Source files
------------

// File: rtl/sync_fifo_width_packer.sv
// sync_fifo_width_packer
// Packs RATIO narrow upstream words into one OUT_WIDTH word for the sync_fifo
// write side. A lane-valid mask (o_keep) accompanies each packed word so that
// a word cut short by i_last can be flushed with only its received lanes
// marked valid. The packed word, mask and valid bit are registered.
//
// Build option: define SYNC_FIFO_PACKER_MSB_FIRST_EN to place the first
// received word in the MSBs of o_data (default: first word in the LSBs).
// o_keep bit k always refers to the k-th received word in either build.

module sync_fifo_width_packer #(
  parameter int IN_WIDTH  = 8,
  parameter int RATIO     = 4,
  parameter int OUT_WIDTH = IN_WIDTH * RATIO,
  parameter int CNT_WIDTH = $clog2(RATIO)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid_s,
  input  logic [IN_WIDTH-1:0]  i_data,
  input  logic                 i_last,
  output logic                 o_ready_s,
  output logic                 o_valid_m,
  output logic [OUT_WIDTH-1:0] o_data,
  output logic [RATIO-1:0]     o_keep,
  input  logic                 i_ready_m
);

  localparam int                   ACC_WIDTH = (RATIO - 1) * IN_WIDTH;
  localparam logic [CNT_WIDTH-1:0] LAST_LANE = CNT_WIDTH'(RATIO - 1);

  typedef enum logic [0:0] {
    ST_ACCUM      = 1'b0,
    ST_FLUSH_PEND = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [OUT_WIDTH-1:0]   data_q, data_d;
  logic [RATIO-1:0]       keep_q, keep_d;
  logic                   valid_q, valid_d;

  logic                   out_free_s;
  logic                   in_fire_s;
  logic                   load_s;
  logic [OUT_WIDTH-1:0]   acc_ext_s;
  logic [OUT_WIDTH-1:0]   packed_s;
  logic [RATIO-1:0]       keep_s;
  logic [IN_WIDTH-1:0]    lane_s;

  // The output register can take a new word when empty or draining this cycle.
  assign out_free_s = ~valid_q | i_ready_m;

  // A full word needs out_free; a flush in progress blocks all input.
  assign o_ready_s = i_rst_n & (state_q == ST_ACCUM) &
                     ((cnt_q != LAST_LANE) | out_free_s);

  assign in_fire_s = i_valid_s & o_ready_s;

  // Accumulator widened to RATIO lanes so every lane index is in range.
  assign acc_ext_s = {{IN_WIDTH{1'b0}}, acc_q};

  // Assemble the candidate packed word: lanes 0..cnt valid, upper lanes zero.
  // In ACCUM the completing lane comes straight from i_data; in FLUSH_PEND it
  // was already written into the accumulator.
  always_comb begin
    packed_s = {OUT_WIDTH{1'b0}};
    keep_s   = {RATIO{1'b0}};
    lane_s   = {IN_WIDTH{1'b0}};
    for (int k = 0; k < RATIO; k++) begin
      if ((CNT_WIDTH'(k) == cnt_q) && (state_q == ST_ACCUM)) begin
        lane_s = i_data;
      end else if (CNT_WIDTH'(k) <= cnt_q) begin
        lane_s = acc_ext_s[k*IN_WIDTH +: IN_WIDTH];
      end else begin
        lane_s = {IN_WIDTH{1'b0}};
      end
      keep_s[k] = (CNT_WIDTH'(k) <= cnt_q);
`ifdef SYNC_FIFO_PACKER_MSB_FIRST_EN
      packed_s[(RATIO-1-k)*IN_WIDTH +: IN_WIDTH] = lane_s;
`else
      packed_s[k*IN_WIDTH +: IN_WIDTH] = lane_s;
`endif
    end
  end

  // Next-state, lane counter, accumulator and output-register load decisions.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    data_d  = data_q;
    keep_d  = keep_q;
    valid_d = valid_q;
    load_s  = 1'b0;

    if (valid_q && i_ready_m) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end

    case (state_q)
      ST_ACCUM: begin
        if (in_fire_s) begin
          if (cnt_q == LAST_LANE) begin
            load_s = 1'b1;
            cnt_d  = {CNT_WIDTH{1'b0}};
          end else if (!i_last) begin
            for (int k = 0; k < RATIO - 1; k++) begin
              if (CNT_WIDTH'(k) == cnt_q) begin
                acc_d[k*IN_WIDTH +: IN_WIDTH] = i_data;
              end else begin
                acc_d[k*IN_WIDTH +: IN_WIDTH] = acc_q[k*IN_WIDTH +: IN_WIDTH];
              end
            end
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end else if (out_free_s) begin
            load_s = 1'b1;
            cnt_d  = {CNT_WIDTH{1'b0}};
          end else begin
            // Partial word cannot leave yet: park it and hold cnt as its last lane.
            for (int k = 0; k < RATIO - 1; k++) begin
              if (CNT_WIDTH'(k) == cnt_q) begin
                acc_d[k*IN_WIDTH +: IN_WIDTH] = i_data;
              end else begin
                acc_d[k*IN_WIDTH +: IN_WIDTH] = acc_q[k*IN_WIDTH +: IN_WIDTH];
              end
            end
            state_d = ST_FLUSH_PEND;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_FLUSH_PEND: begin
        if (out_free_s) begin
          load_s  = 1'b1;
          cnt_d   = {CNT_WIDTH{1'b0}};
          state_d = ST_ACCUM;
        end else begin
          state_d = ST_FLUSH_PEND;
        end
      end
      default: begin
        state_d = ST_ACCUM;
        cnt_d   = {CNT_WIDTH{1'b0}};
      end
    endcase

    // A load wins over a same-cycle drain, giving back-to-back words.
    if (load_s) begin
      valid_d = 1'b1;
      data_d  = packed_s;
      keep_d  = keep_s;
    end else begin
      data_d  = data_q;
      keep_d  = keep_q;
    end
  end

  // State, counter, accumulator and output register with asynchronous clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_ACCUM;
      cnt_q   <= {CNT_WIDTH{1'b0}};
      acc_q   <= {ACC_WIDTH{1'b0}};
      data_q  <= {OUT_WIDTH{1'b0}};
      keep_q  <= {RATIO{1'b0}};
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      valid_q <= valid_d;
    end
  end

  assign o_valid_m = valid_q;
  assign o_data    = data_q;
  assign o_keep    = keep_q;

endmodule

// File: tb/tb_sync_fifo_width_packer.sv
// Self-checking bench for sync_fifo_width_packer (IN_WIDTH=8, RATIO=4).
// A queue-based reference model predicts o_ready_s, o_valid_m, o_data, o_keep.
// Honours SYNC_FIFO_PACKER_MSB_FIRST_EN for lane placement.

module tb_sync_fifo_width_packer;

  logic        clk;
  logic        rst_n;
  logic        valid_s;
  logic [7:0]  data_in;
  logic        last;
  logic        ready_s;
  logic        valid_m;
  logic [31:0] data_out;
  logic [3:0]  keep;
  logic        ready_m;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [7:0]  bytes_q[$];
  logic [31:0] out_data_q[$];
  logic [3:0]  out_keep_q[$];
  logic        pend_valid;
  logic [31:0] pend_data;
  logic [3:0]  pend_keep;

`ifdef SYNC_FIFO_PACKER_MSB_FIRST_EN
  localparam logic [31:0] EXP_FULL  = 32'h11223344;
  localparam logic [31:0] EXP_PART  = 32'hAABB0000;
  localparam logic [31:0] EXP_HOLD  = 32'hC1C2C3C4;
  localparam logic [31:0] EXP_NEXT  = 32'h01020304;
  localparam logic [31:0] EXP_ONE   = 32'h5A000000;
  localparam logic [31:0] EXP_RST   = 32'h33445566;
`else
  localparam logic [31:0] EXP_FULL  = 32'h44332211;
  localparam logic [31:0] EXP_PART  = 32'h0000BBAA;
  localparam logic [31:0] EXP_HOLD  = 32'hC4C3C2C1;
  localparam logic [31:0] EXP_NEXT  = 32'h04030201;
  localparam logic [31:0] EXP_ONE   = 32'h0000005A;
  localparam logic [31:0] EXP_RST   = 32'h66554433;
`endif

  sync_fifo_width_packer dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_valid_s (valid_s),
    .i_data    (data_in),
    .i_last    (last),
    .o_ready_s (ready_s),
    .o_valid_m (valid_m),
    .o_data    (data_out),
    .o_keep    (keep),
    .i_ready_m (ready_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    bytes_q.delete();
    out_data_q.delete();
    out_keep_q.delete();
    pend_valid = 1'b0;
    pend_data  = 32'h0;
    pend_keep  = 4'h0;
  endtask

  // Build a packed word from the bytes collected so far.
  task automatic make_word(output logic [31:0] w, output logic [3:0] k);
    w = 32'h0;
    k = 4'h0;
    for (int i = 0; i < bytes_q.size(); i++) begin
`ifdef SYNC_FIFO_PACKER_MSB_FIRST_EN
      w[(3-i)*8 +: 8] = bytes_q[i];
`else
      w[i*8 +: 8] = bytes_q[i];
`endif
      k[i] = 1'b1;
    end
  endtask

  // One clock: drive inputs, compare at negedge, advance model at the edge.
  task automatic step(input logic v, input logic [7:0] d, input logic l, input logic r);
    logic        out_free;
    logic        exp_ready;
    logic [31:0] w;
    logic [3:0]  k;
    valid_s = v;
    data_in = d;
    last    = l;
    ready_m = r;
    @(negedge clk);
    out_free  = (out_data_q.size() == 0) || r;
    exp_ready = !pend_valid && ((bytes_q.size() < 3) || out_free);
    chk("ready_s", 32'(ready_s), 32'(exp_ready));
    chk("valid_m", 32'(valid_m), 32'(out_data_q.size() != 0));
    if (out_data_q.size() != 0) begin
      chk("data", data_out, out_data_q[0]);
      chk("keep", 32'(keep), 32'(out_keep_q[0]));
    end
    if ((out_data_q.size() != 0) && r) begin
      void'(out_data_q.pop_front());
      void'(out_keep_q.pop_front());
    end
    if (pend_valid && out_free) begin
      out_data_q.push_back(pend_data);
      out_keep_q.push_back(pend_keep);
      pend_valid = 1'b0;
    end else if (v && exp_ready) begin
      bytes_q.push_back(d);
      if ((bytes_q.size() == 4) || l) begin
        make_word(w, k);
        bytes_q.delete();
        if (out_free) begin
          out_data_q.push_back(w);
          out_keep_q.push_back(k);
        end else begin
          pend_valid = 1'b1;
          pend_data  = w;
          pend_keep  = k;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n   = 1'b0;
    valid_s = 1'b0;
    data_in = 8'h0;
    last    = 1'b0;
    ready_m = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready_low", 32'(ready_s), 32'h0);
    rst_n = 1'b1;
    #1;
    chk("idle_ready", 32'(ready_s), 32'h1);
    chk("idle_valid", 32'(valid_m), 32'h0);
    chk("idle_data", data_out, 32'h0);
    chk("idle_keep", 32'(keep), 32'h0);

    // full word, then two back-to-back words
    step(1'b1, 8'h11, 1'b0, 1'b1);
    step(1'b1, 8'h22, 1'b0, 1'b1);
    step(1'b1, 8'h33, 1'b0, 1'b1);
    step(1'b1, 8'h44, 1'b0, 1'b1);
    chk("full_valid", 32'(valid_m), 32'h1);
    chk("full_data", data_out, EXP_FULL);
    chk("full_keep", 32'(keep), 32'hF);
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h51 + i), 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // partial word flushed by i_last
    step(1'b1, 8'hAA, 1'b0, 1'b1);
    step(1'b1, 8'hBB, 1'b1, 1'b1);
    chk("part_data", data_out, EXP_PART);
    chk("part_keep", 32'(keep), 32'h3);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // backpressure: word held, fourth byte refused until drain
    step(1'b1, 8'hC1, 1'b0, 1'b0);
    step(1'b1, 8'hC2, 1'b0, 1'b0);
    step(1'b1, 8'hC3, 1'b0, 1'b0);
    step(1'b1, 8'hC4, 1'b0, 1'b0);
    step(1'b1, 8'h01, 1'b0, 1'b0);
    step(1'b1, 8'h02, 1'b0, 1'b0);
    step(1'b1, 8'h03, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 8'h04, 1'b0, 1'b0);
      chk("hold_ready", 32'(ready_s), 32'h0);
      chk("hold_data", data_out, EXP_HOLD);
    end
    step(1'b1, 8'h04, 1'b0, 1'b1);
    chk("next_valid", 32'(valid_m), 32'h1);
    chk("next_data", data_out, EXP_NEXT);

    // single-lane flush while the output is blocked
    step(1'b1, 8'h5A, 1'b1, 1'b0);
    chk("flush_ready", 32'(ready_s), 32'h0);
    step(1'b1, 8'h77, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("one_data", data_out, EXP_ONE);
    chk("one_keep", 32'(keep), 32'h1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("accum_ready", 32'(ready_s), 32'h1);

    // reset mid-word discards the partial word
    step(1'b1, 8'h11, 1'b0, 1'b1);
    step(1'b1, 8'h22, 1'b0, 1'b1);
    valid_s = 1'b0;
    rst_n   = 1'b0;
    #2;
    chk("midrst_ready", 32'(ready_s), 32'h0);
    chk("midrst_valid", 32'(valid_m), 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b1, 8'h33, 1'b0, 1'b1);
    step(1'b1, 8'h44, 1'b0, 1'b1);
    step(1'b1, 8'h55, 1'b0, 1'b1);
    step(1'b1, 8'h66, 1'b0, 1'b1);
    chk("rst_word", data_out, EXP_RST);

    // reset in the middle of a pending flush
    step(1'b1, 8'h01, 1'b1, 1'b0);
    step(1'b1, 8'h02, 1'b1, 1'b0);
    rst_n = 1'b0;
    #2;
    model_reset();
    chk("flushrst_valid", 32'(valid_m), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0, 8'($urandom),
           ($urandom_range(0, 9) < 2) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0);
    end

    // bounded drain
    for (int i = 0; i < 10; i++) begin
      if ((out_data_q.size() != 0) || pend_valid) step(1'b0, 8'h00, 1'b0, 1'b1);
    end
    chk("drain_done", 32'((out_data_q.size() != 0) || pend_valid), 32'h0);
    chk("drain_valid", 32'(valid_m), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
